// File: rtl/roach_clk_rst_sequencer_if.sv
// ----------------------------------------------------------------------------
// roach_clk_rst_sequencer_if
// Bundles the status inputs and reset/status outputs of the infrastructure
// clock/reset sequencer.
//   master : the sequencer itself (samples locks/RDY/restart, drives resets)
//   slave  : the clocking infrastructure and system side
// Signals:
//   mmcm_locked     N_MMCM  MMCM LOCKED outputs, asynchronous to clk
//   idelay_rdy      1       IDELAYCTRL RDY, asynchronous to clk
//   restart         1       soft restart pulse, synchronous to clk
//   mmcm_rst        N_MMCM  MMCM RST pins
//   idelay_rst      1       IDELAYCTRL RST
//   op_power_on_rst 1       design-wide reset, active-high
//   sys_ready       1       system running and not faulted
//   fault           1       retries exhausted
//   lock_loss_cnt   8       saturating count of lock drops seen in RUN
//   state           3       current FSM state (debug)
// ----------------------------------------------------------------------------
interface roach_clk_rst_sequencer_if #(
    parameter int N_MMCM = 2
);
    logic [N_MMCM-1:0] mmcm_locked;
    logic              idelay_rdy;
    logic              restart;
    logic [N_MMCM-1:0] mmcm_rst;
    logic              idelay_rst;
    logic              op_power_on_rst;
    logic              sys_ready;
    logic              fault;
    logic [7:0]        lock_loss_cnt;
    logic [2:0]        state;

    modport master (
        input  mmcm_locked, idelay_rdy, restart,
        output mmcm_rst, idelay_rst, op_power_on_rst, sys_ready, fault,
               lock_loss_cnt, state
    );

    modport slave (
        output mmcm_locked, idelay_rdy, restart,
        input  mmcm_rst, idelay_rst, op_power_on_rst, sys_ready, fault,
               lock_loss_cnt, state
    );
endinterface

// File: rtl/roach_clk_rst_sequencer.sv
// ----------------------------------------------------------------------------
// roach_clk_rst_sequencer
// Power-up and recovery sequencer for the infrastructure clocking. Pulses the
// MMCM resets, waits for all locks to be stable, pulses the IDELAYCTRL reset,
// waits for RDY and only then releases op_power_on_rst. Lock loss re-sequences;
// repeated timeouts park the block in FAULT until restart or rst.
// Ports:
//   clk  free-running reference clock
//   rst  asynchronous active-high reset
//   bus  roach_clk_rst_sequencer_if.master (locks, RDY, restart in; resets,
//        status and debug state out)
// ----------------------------------------------------------------------------
module roach_clk_rst_sequencer #(
    parameter int N_MMCM            = 2,
    parameter int MMCM_RST_CYCLES   = 16,
    parameter int STABLE_CYCLES     = 256,
    parameter int IDELAY_RST_CYCLES = 16,
    parameter int TIMEOUT_CYCLES    = 65535,
    parameter int MAX_RETRIES       = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    roach_clk_rst_sequencer_if.master       bus
);

    localparam int MAX_RST   = (MMCM_RST_CYCLES > IDELAY_RST_CYCLES) ? MMCM_RST_CYCLES : IDELAY_RST_CYCLES;
    localparam int MAX_WAIT  = (STABLE_CYCLES > TIMEOUT_CYCLES) ? STABLE_CYCLES : TIMEOUT_CYCLES;
    localparam int MAX_CYC   = (MAX_RST > MAX_WAIT) ? MAX_RST : MAX_WAIT;
    localparam int CNT_W     = $clog2(MAX_CYC) + 1;

    // Terminal counts: the counter starts at 0 on entry, so a state lasting
    // N cycles leaves on the edge where the counter holds N-1.
    localparam logic [CNT_W-1:0] MRST_LAST = CNT_W'(MMCM_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] IRST_LAST = CNT_W'(IDELAY_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_MRST  = 3'd0,
        ST_WLOCK = 3'd1,
        ST_STAB  = 3'd2,
        ST_IRST  = 3'd3,
        ST_WRDY  = 3'd4,
        ST_RUN   = 3'd5,
        ST_FAULT = 3'd6
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [3:0]        retry_reg, retry_next;
    logic [7:0]        loss_reg, loss_next;

    logic [N_MMCM-1:0] locked_meta_reg, locked_sync_reg;
    logic              rdy_meta_reg, rdy_sync_reg;
    logic              lock_all;

    logic [N_MMCM-1:0] mmcm_rst_reg;
    logic              idelay_rst_reg, por_reg, sys_ready_reg, fault_reg;

    // Two-flop synchronisers, one per LOCKED bit and one for RDY.
    generate
        for (genvar gi = 0; gi < N_MMCM; gi++) begin : g_lock_sync
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    locked_meta_reg[gi] <= 1'b0;
                    locked_sync_reg[gi] <= 1'b0;
                end else begin
                    locked_meta_reg[gi] <= bus.mmcm_locked[gi];
                    locked_sync_reg[gi] <= locked_meta_reg[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_meta_reg <= 1'b0;
            rdy_sync_reg <= 1'b0;
        end else begin
            rdy_meta_reg <= bus.idelay_rdy;
            rdy_sync_reg <= rdy_meta_reg;
        end
    end

    assign lock_all = &locked_sync_reg;

    always_comb begin
        logic       do_retry;
        logic [3:0] retry_inc;
        state_next = state_reg;
        retry_next = retry_reg;
        loss_next  = loss_reg;
        do_retry   = 1'b0;
        retry_inc  = retry_reg + 4'd1;

        if (bus.restart) begin
            state_next = ST_MRST;
            retry_next = 4'd0;
        end else begin
            case (state_reg)
                ST_MRST:  if (cnt_reg == MRST_LAST) state_next = ST_WLOCK;
                // Lock is checked first so a lock arriving on the timeout
                // cycle is not charged as a retry.
                ST_WLOCK: if (lock_all)                  state_next = ST_STAB;
                          else if (cnt_reg == TO_LAST)   do_retry   = 1'b1;
                ST_STAB:  if (!lock_all)                 state_next = ST_WLOCK;
                          else if (cnt_reg == STAB_LAST) state_next = ST_IRST;
                ST_IRST:  if (!lock_all)                 state_next = ST_WLOCK;
                          else if (cnt_reg == IRST_LAST) state_next = ST_WRDY;
                ST_WRDY:  if (!lock_all)                 state_next = ST_WLOCK;
                          else if (rdy_sync_reg)         state_next = ST_RUN;
                          else if (cnt_reg == TO_LAST)   do_retry   = 1'b1;
                // Lock loss outranks RDY loss and is the only event counted.
                ST_RUN: begin
                    if (!lock_all) begin
                        state_next = ST_MRST;
                        if (loss_reg != 8'hff) loss_next = loss_reg + 8'd1;
                    end else if (!rdy_sync_reg) begin
                        state_next = ST_IRST;
                    end
                end
                ST_FAULT: state_next = ST_FAULT;
                default:  state_next = ST_MRST;
            endcase

            if (do_retry) begin
                retry_next = retry_inc;
                state_next = (retry_inc == RETRY_MAX) ? ST_FAULT : ST_MRST;
            end
            if (state_next == ST_RUN && state_reg != ST_RUN) retry_next = 4'd0;
        end

        // Restart into MRST from MRST is still a fresh entry.
        cnt_next = (state_next != state_reg || bus.restart) ? '0 : cnt_reg + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_MRST;
            cnt_reg        <= '0;
            retry_reg      <= 4'd0;
            loss_reg       <= 8'd0;
            mmcm_rst_reg   <= '1;
            idelay_rst_reg <= 1'b1;
            por_reg        <= 1'b1;
            sys_ready_reg  <= 1'b0;
            fault_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            retry_reg      <= retry_next;
            loss_reg       <= loss_next;
            // Outputs decode the next state so they move with the state register.
            mmcm_rst_reg   <= {N_MMCM{state_next == ST_MRST || state_next == ST_FAULT}};
            idelay_rst_reg <= (state_next == ST_MRST)  || (state_next == ST_WLOCK) ||
                              (state_next == ST_STAB)  || (state_next == ST_IRST)  ||
                              (state_next == ST_FAULT);
            por_reg        <= (state_next != ST_RUN);
            sys_ready_reg  <= (state_next == ST_RUN);
            fault_reg      <= (state_next == ST_FAULT);
        end
    end

    assign bus.mmcm_rst        = mmcm_rst_reg;
    assign bus.idelay_rst      = idelay_rst_reg;
    assign bus.op_power_on_rst = por_reg;
    assign bus.sys_ready       = sys_ready_reg;
    assign bus.fault           = fault_reg;
    assign bus.lock_loss_cnt   = loss_reg;
    assign bus.state           = state_reg;

endmodule

// File: tb/tb_roach_clk_rst_sequencer.sv
module tb_roach_clk_rst_sequencer;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    roach_clk_rst_sequencer_if #(.N_MMCM(2)) bus ();

    roach_clk_rst_sequencer #(
        .N_MMCM            (2),
        .MMCM_RST_CYCLES   (4),
        .STABLE_CYCLES     (8),
        .IDELAY_RST_CYCLES (4),
        .TIMEOUT_CYCLES    (32),
        .MAX_RETRIES       (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            begin
                n_fail++;
                $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
            end
        else
            $display("ok   %s: %0d", tag, got);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n;
        n = 0;
        while (bus.state != s && n < budget) begin
            step();
            n++;
        end
        check_eq(tag, 32'(bus.state), 32'(s));
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_state"},  32'(bus.state), 0);
        check_eq({tag, "_mmcm"},   32'(bus.mmcm_rst), 3);
        check_eq({tag, "_idelay"}, 32'(bus.idelay_rst), 1);
        check_eq({tag, "_por"},    32'(bus.op_power_on_rst), 1);
        check_eq({tag, "_ready"},  32'(bus.sys_ready), 0);
        check_eq({tag, "_fault"},  32'(bus.fault), 0);
        check_eq({tag, "_loss"},   32'(bus.lock_loss_cnt), 0);
    endtask

    initial begin
        int mrst_hi, irst_n, irst_hi, mm_hi, lat, run_len, stints;
        logic prev_por, prev_rdy, seen_run, saw_wlock;

        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.mmcm_locked = 2'b00;
        bus.idelay_rdy  = 1'b0;
        bus.restart     = 1'b0;
        repeat (3) step();
        check_reset_vals("reset");

        // 1: cold boot, locks and RDY rise at cycle 10
        rst = 1'b0;
        mrst_hi = 0; irst_n = 0; irst_hi = 0;
        prev_por = 1'b1; prev_rdy = 1'b0; seen_run = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (c == 10) begin
                bus.mmcm_locked = 2'b11;
                bus.idelay_rdy  = 1'b1;
            end
            if (bus.mmcm_rst == 2'b11) mrst_hi++;
            if (bus.state == 3'd3) begin
                irst_n++;
                if (bus.idelay_rst) irst_hi++;
            end
            if (bus.state == 3'd5) begin
                seen_run = 1'b1;
                check_eq("t1_por_ready_edge", {28'd0, prev_por, prev_rdy, bus.op_power_on_rst, bus.sys_ready}, 32'b1001);
                break;
            end
            prev_por = bus.op_power_on_rst;
            prev_rdy = bus.sys_ready;
            step();
        end
        check_eq("t1_reached_run", 32'(seen_run), 1);
        check_eq("t1_mmcm_rst_cycles", mrst_hi, 4);
        check_eq("t1_irst_cycles", irst_n, 4);
        check_eq("t1_idelay_rst_cycles", irst_hi, 4);
        check_eq("t1_loss", 32'(bus.lock_loss_cnt), 0);

        // 2: lock bounce in STAB at stable count 5
        bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
        check_eq("t2_restart_state", 32'(bus.state), 0);
        wait_state(3'd2, 40, "t2_enter_stab");
        repeat (5) step();
        bus.mmcm_locked = 2'b01;
        saw_wlock = 1'b0;
        repeat (3) begin
            step();
            if (bus.state == 3'd1) saw_wlock = 1'b1;
        end
        bus.mmcm_locked = 2'b11;
        for (int n = 0; n < 20 && bus.state != 3'd2; n++) begin
            if (bus.state == 3'd1) saw_wlock = 1'b1;
            step();
        end
        check_eq("t2_saw_wlock", 32'(saw_wlock), 1);
        lat = 0;
        while (bus.state == 3'd2 && lat < 40) begin
            lat++;
            step();
        end
        check_eq("t2_stab_window", lat, 8);
        check_eq("t2_next_irst", 32'(bus.state), 3);
        check_eq("t2_loss", 32'(bus.lock_loss_cnt), 0);
        check_eq("t2_fault", 32'(bus.fault), 0);
        wait_state(3'd5, 60, "t2_run");

        // 5: RDY loss in RUN
        bus.idelay_rdy = 1'b0;
        wait_state(3'd3, 10, "t5_enter_irst");
        irst_n = 0; irst_hi = 0; mm_hi = 0;
        while (bus.state == 3'd3 && irst_n < 20) begin
            irst_n++;
            if (bus.idelay_rst) irst_hi++;
            if (bus.mmcm_rst != 2'b00) mm_hi++;
            step();
        end
        check_eq("t5_irst_cycles", irst_n, 4);
        check_eq("t5_idelay_rst_cycles", irst_hi, 4);
        check_eq("t5_mmcm_rst_high", mm_hi, 0);
        check_eq("t5_idelay_rst_after", 32'(bus.idelay_rst), 0);
        bus.idelay_rdy = 1'b1;
        wait_state(3'd5, 40, "t5_run");
        check_eq("t5_loss", 32'(bus.lock_loss_cnt), 0);

        // 3: lock loss in RUN, then saturation over 300 drops
        bus.mmcm_locked = 2'b10;
        lat = 0;
        while (bus.mmcm_rst != 2'b11 && lat < 10) begin
            step();
            lat++;
        end
        check_eq("t3_latency_ok", 32'(lat >= 2 && lat <= 3), 1);
        check_eq("t3_por", 32'(bus.op_power_on_rst), 1);
        check_eq("t3_loss1", 32'(bus.lock_loss_cnt), 1);
        bus.mmcm_locked = 2'b11;
        for (int i = 1; i < 300; i++) begin
            wait_state(3'd5, 60, "t3_run");
            bus.mmcm_locked = 2'b10;
            wait_state(3'd0, 10, "t3_mrst");
            bus.mmcm_locked = 2'b11;
            if (i == 199) check_eq("t3_loss200", 32'(bus.lock_loss_cnt), 200);
        end
        wait_state(3'd5, 60, "t3_final_run");
        check_eq("t3_loss_sat", 32'(bus.lock_loss_cnt), 255);

        // 4: locks held low -> three WLOCK timeouts -> FAULT
        bus.mmcm_locked = 2'b00;
        wait_state(3'd0, 10, "t4_mrst");
        run_len = 0; stints = 0;
        for (int n = 0; n < 400; n++) begin
            if (bus.state == 3'd1) begin
                run_len++;
            end else if (run_len != 0) begin
                stints++;
                check_eq("t4_wlock_len", run_len, 32);
                run_len = 0;
            end
            if (bus.state == 3'd6) break;
            step();
        end
        check_eq("t4_timeouts", stints, 3);
        check_eq("t4_state", 32'(bus.state), 6);
        check_eq("t4_fault", 32'(bus.fault), 1);
        check_eq("t4_mmcm_rst", 32'(bus.mmcm_rst), 3);
        check_eq("t4_idelay_rst", 32'(bus.idelay_rst), 1);
        check_eq("t4_por", 32'(bus.op_power_on_rst), 1);
        check_eq("t4_ready", 32'(bus.sys_ready), 0);
        repeat (5) step();
        check_eq("t4_parked", 32'(bus.state), 6);
        bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
        check_eq("t4_restart_state", 32'(bus.state), 0);
        check_eq("t4_restart_fault", 32'(bus.fault), 0);
        check_eq("t4_loss_kept", 32'(bus.lock_loss_cnt), 255);

        // 6: asynchronous reset in the middle of IRST
        bus.mmcm_locked = 2'b11;
        bus.idelay_rdy  = 1'b1;
        wait_state(3'd3, 40, "t6_enter_irst");
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("t6_async");
        step();
        rst = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
